prg_loader: RTL and testbench

PRG_LOADER -- requirements
Module: prg_loader

---
 rtl/prg_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_prg_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_loader.sv
// prg_loader: turns an hps_io download stream into byte writes on a DMA port.
//
// A PRG download (index PRG_INDEX) carries a 2-byte little-endian load address
// followed by data. Data bytes pass through a one-entry holding buffer to the
// DMA port, starting at the load address. Bytes at or above MEM_TOP are dropped
// and flag overflow. When the download ends, NPTR 16-bit copies of the end
// address are written starting at PTR_BASE, and done pulses once.
//
// Optional feature: define PRG_LOADER_ROM_EN to accept ROM downloads
// (index ROM_INDEX). A ROM byte at stream offset N is written to ROM_BASE+N.
// Bytes at offsets of ROM_SIZE or more are discarded.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   ioctl_download/index/wr/addr/dout  download stream from hps_io
//   ioctl_wait            back-pressure; high while the holding buffer is full
//   dma_ready             memory side accepts a write this cycle
//   dma_addr/din/we       byte write port
//   busy                  loader is not idle
//   done                  one-cycle pulse when a PRG load completes
//   overflow              sticky; PRG data was dropped at or above MEM_TOP
//   end_addr              address one past the last PRG byte written
module prg_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_TOP   = 'h8000,
  parameter logic [7:0]  PRG_INDEX = 8'h41,
  parameter int unsigned PTR_BASE  = 'h2A,
  parameter int unsigned NPTR      = 3,
  parameter logic [7:0]  ROM_INDEX = 8'h02,
  parameter int unsigned ROM_BASE  = 'h8000,
  parameter int unsigned ROM_SIZE  = 'h8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              dma_ready,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_din,
  output logic              dma_we,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       end_addr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PTR  = 3'd3;
`ifdef PRG_LOADER_ROM_EN
  localparam logic [2:0] S_ROM  = 3'd4;
`else
  logic unused_rom;
  assign unused_rom = ^{ROM_INDEX, ROM_BASE, ROM_SIZE};
`endif

  localparam logic [2:0] PTR_LAST = 3'(2 * NPTR - 1);

  logic [2:0]        state_q, state_d;
  logic              dl_q;
  logic [15:0]       load_addr_q, load_addr_d;
  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic              dma_we_q, dma_we_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
  logic [7:0]        dma_din_q, dma_din_d;
  logic [2:0]        ptr_cnt_q, ptr_cnt_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic [15:0]       end_addr_q, end_addr_d;

  logic rise, drain, slot_free, wr_prg;

  assign rise      = ioctl_download && !dl_q;
  assign drain     = buf_full_q && dma_ready;
  // A byte may land in the entry being drained this same cycle.
  assign slot_free = !buf_full_q || drain;
  assign wr_prg    = ioctl_wr && (ioctl_index == PRG_INDEX);

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    buf_full_d  = buf_full_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    dma_we_d    = 1'b0;
    dma_addr_d  = dma_addr_q;
    dma_din_d   = dma_din_q;
    ptr_cnt_d   = ptr_cnt_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    end_addr_d  = end_addr_q;

    // The buffer drains independently of the state so a byte captured just
    // before the download ends still reaches memory.
    if (drain) begin
      dma_we_d   = 1'b1;
      dma_addr_d = buf_addr_q;
      dma_din_d  = buf_data_q;
      buf_full_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rise && ioctl_index == PRG_INDEX) begin
          state_d    = S_HDR;
          overflow_d = 1'b0;
        end
`ifdef PRG_LOADER_ROM_EN
        else if (rise && ioctl_index == ROM_INDEX) state_d = S_ROM;
`endif
      end
      S_HDR: begin
        if (!ioctl_download) state_d = S_IDLE;
        else if (wr_prg) begin
          if (ioctl_addr == 25'd0) load_addr_d[7:0] = ioctl_dout;
          else if (ioctl_addr == 25'd1) begin
            load_addr_d[15:8] = ioctl_dout;
            state_d           = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (wr_prg && slot_free) begin
          if (32'(load_addr_q) < MEM_TOP) begin
            buf_full_d  = 1'b1;
            buf_addr_d  = ADDR_W'(load_addr_q);
            buf_data_d  = ioctl_dout;
            load_addr_d = load_addr_q + 16'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (!ioctl_download && !buf_full_q) begin
          state_d   = S_PTR;
          ptr_cnt_d = '0;
        end
      end
      S_PTR: begin
        if (rise && ioctl_index == PRG_INDEX) begin
          state_d    = S_HDR;
          overflow_d = 1'b0;
        end
`ifdef PRG_LOADER_ROM_EN
        else if (rise && ioctl_index == ROM_INDEX) state_d = S_ROM;
`endif
        else if (dma_ready) begin
          dma_we_d   = 1'b1;
          dma_addr_d = ADDR_W'(PTR_BASE + 32'(ptr_cnt_q));
          dma_din_d  = ptr_cnt_q[0] ? load_addr_q[15:8] : load_addr_q[7:0];
          if (ptr_cnt_q == PTR_LAST) begin
            end_addr_d = load_addr_q;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
            ptr_cnt_d = ptr_cnt_q + 3'd1;
          end
        end
      end
`ifdef PRG_LOADER_ROM_EN
      S_ROM: begin
        if (!ioctl_download) state_d = S_IDLE;
        else if (ioctl_wr && ioctl_index == ROM_INDEX && slot_free &&
                 32'(ioctl_addr) < ROM_SIZE) begin
          buf_full_d = 1'b1;
          buf_addr_d = ADDR_W'(ROM_BASE + 32'(ioctl_addr));
          buf_data_d = ioctl_dout;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Tracking the level through reset avoids a false start if the download
    // is still high when reset is released.
    dl_q <= ioctl_download;
    if (reset) begin
      state_q     <= S_IDLE;
      load_addr_q <= '0;
      buf_full_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      dma_we_q    <= 1'b0;
      dma_addr_q  <= '0;
      dma_din_q   <= '0;
      ptr_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      end_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      buf_full_q  <= buf_full_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      dma_we_q    <= dma_we_d;
      dma_addr_q  <= dma_addr_d;
      dma_din_q   <= dma_din_d;
      ptr_cnt_q   <= ptr_cnt_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      end_addr_q  <= end_addr_d;
    end
  end

  assign ioctl_wait = buf_full_q;
  assign dma_we     = dma_we_q;
  assign dma_addr   = dma_addr_q;
  assign dma_din    = dma_din_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign end_addr   = end_addr_q;

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: a reference model pushes the expected
// DMA writes per download into a queue; a monitor pops and compares on
// every dma_we.
module tb_prg_loader;

  localparam int unsigned MEM_TOP  = 'h8000;
  localparam int unsigned PTR_BASE = 'h2A;
  localparam int unsigned NPTR     = 3;
  localparam int unsigned ROM_BASE = 'h8000;
  localparam int unsigned ROM_SIZE = 'h8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        dma_ready = 1'b1;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we, busy, done, overflow;
  logic [15:0] end_addr;

  always #5 clk = ~clk;

  prg_loader dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .dma_ready(dma_ready),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .busy(busy), .done(done), .overflow(overflow), .end_addr(end_addr)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] expq[$];
  int done_cnt = 0;
  int ready_hold = 0;
  bit rand_ready = 1'b0;
  bit wait_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every DMA write must match the head of the expectation queue.
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (dma_we) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dma_unexpected actual=%h:%h required=none", dma_addr, dma_din);
        end else begin
          e = expq.pop_front();
          chk("dma_write", {8'h00, dma_addr, dma_din}, {8'h00, e});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    if (ready_hold > 0) begin
      dma_ready = 1'b0;
      ready_hold--;
      if (wait_chk) chk("wait_during_stall", 32'(ioctl_wait), 32'd1);
    end else begin
      dma_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    ioctl_wr = 1'b0;
    tick();
  endtask

  // Issue one write once the loader can take it (buffer empty or draining).
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    step();
    while (ioctl_wait && !dma_ready && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout actual=wait_stuck required=accept");
    end else begin
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
    end
  endtask

  task automatic wait_idle(input int start_done, input int exp_done,
                           input logic [15:0] exp_end, input bit exp_ovf);
    int n = 0;
    step();
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_count", 32'(done_cnt - start_done), 32'(exp_done));
    if (exp_done != 0) chk("end_addr", 32'(end_addr), 32'(exp_end));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("queue_empty", 32'(expq.size()), 32'd0);
  endtask

  // Reference model + driver for one PRG download (header included in bytes).
  task automatic run_prg(input logic [7:0] bytes[$], input bit stall);
    logic [15:0] load = '0;
    bit ovf = 1'b0;
    int exp_done = 0;
    int start = done_cnt;
    if (bytes.size() >= 2) begin
      exp_done = 1;
      load = {bytes[1], bytes[0]};
      for (int i = 2; i < bytes.size(); i++) begin
        if (32'(load) < MEM_TOP) begin
          expq.push_back({load, bytes[i]});
          load = load + 16'd1;
        end else ovf = 1'b1;
      end
      for (int p = 0; p < 2 * NPTR; p++)
        expq.push_back({16'(PTR_BASE + p), (p % 2 == 1) ? load[15:8] : load[7:0]});
    end
    step();
    ioctl_index    = 8'h41;
    ioctl_download = 1'b1;
    for (int i = 0; i < bytes.size(); i++) begin
      wr_byte(25'(i), bytes[i]);
      if (stall && i == 2) begin
        ready_hold = 5;
        wait_chk   = 1'b1;
      end
    end
    step();
    ioctl_download = 1'b0;
    wait_idle(start, exp_done, load, ovf);
    wait_chk = 1'b0;
  endtask

  // ROM-index or foreign-index download; only an enabled ROM produces writes.
  task automatic run_raw(input logic [7:0] idx, input int n);
    bit rom_on;
    logic [7:0] d[$];
`ifdef PRG_LOADER_ROM_EN
    rom_on = (idx == 8'h02);
`else
    rom_on = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      d.push_back(8'($urandom));
      if (rom_on && i < ROM_SIZE) expq.push_back({16'(ROM_BASE + i), d[i]});
    end
    step();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_byte(25'(i), d[i]);
      if (!rom_on && i < 8) chk("wait_ignored", 32'(ioctl_wait), 32'd0);
    end
    step();
    ioctl_download = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("raw_busy", 32'(busy), 32'd0);
    chk("raw_queue_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(dma_we), 32'd0);
    chk({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_addr"}, 32'(dma_addr), 32'd0);
    chk({tag, "_din"}, 32'(dma_din), 32'd0);
    chk({tag, "_end"}, 32'(end_addr), 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [15:0] h;
    int len;

    reset = 1'b1;
    repeat (3) step();
    chk_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Basic load, then the same stream with a 5-cycle memory stall.
    s = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_prg(s, 1'b0);
    run_prg(s, 1'b1);

    // Load straddling MEM_TOP.
    s = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
    run_prg(s, 1'b0);

    // Header-only abort.
    s = '{8'h01};
    run_prg(s, 1'b0);

    // Reset after the 3rd data byte: only the first two reach memory.
    s = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    expq.push_back({16'h0401, 8'hAA});
    expq.push_back({16'h0402, 8'hBB});
    step();
    ioctl_index    = 8'h41;
    ioctl_download = 1'b1;
    for (int i = 0; i < 5; i++) wr_byte(25'(i), s[i]);
    step();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    step();
    chk_reset_outputs("midrst");
    reset = 1'b0;
    repeat (10) step();
    chk("midrst_queue_empty", 32'(expq.size()), 32'd0);
    run_prg(s, 1'b0);

    // Foreign index is ignored.
    run_raw(8'h33, 12);

    // Randomized loads, half with a randomly stalling memory.
    for (int t = 0; t < 10; t++) begin
      rand_ready = (t % 2 == 1);
      h = ($urandom_range(0, 1) == 1) ? 16'(16'h7FE0 + $urandom_range(0, 31)) : 16'($urandom);
      len = $urandom_range(0, 20);
      s = '{h[7:0], h[15:8]};
      for (int i = 0; i < len; i++) s.push_back(8'($urandom));
      run_prg(s, 1'b0);
    end
    rand_ready = 1'b0;

`ifdef PRG_LOADER_ROM_EN
    run_raw(8'h02, 'h8002);
`else
    run_raw(8'h02, 16);
`endif

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
